// File: rtl/spi_master_param_if.sv
// rtl/spi_master_param_if.sv - TX word stream in and RX word return out of the SPI master
interface spi_master_param_if #(
    parameter int DATA_W = 8
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_dc;
    logic              i_last;
    logic              o_ready;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;

    modport master (
        output i_valid, i_data, i_dc, i_last,
        input  o_ready, o_rx_data, o_rx_valid
    );

    modport slave (
        input  i_valid, i_data, i_dc, i_last,
        output o_ready, o_rx_data, o_rx_valid
    );
endinterface

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master with tagged TX FIFO, all CPOL/CPHA modes, multi-CS
module spi_master_param #(
    parameter  int DATA_W     = 8,
    parameter  int DIV_W      = 8,
    parameter  int NUM_CS     = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    i_div,
    input  logic                i_cpol,
    input  logic                i_cpha,
    input  logic [CS_W-1:0]     i_cs_sel,
    spi_master_param_if.slave   bus,
    output logic                o_busy,
    input  logic                miso,
    output logic                mosi,
    output logic                sclk,
    output logic                dc,
    output logic [NUM_CS-1:0]   cs
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = DATA_W + 2;
    localparam int EDGES = 2 * DATA_W;
    localparam int EGW   = $clog2(EDGES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_XFER, S_NEXT, S_WAIT, S_CS_HOLD
    } state_t;

    state_t r_state, w_state_nxt;

    // FIFO storage and pointers; each entry is {last, dc, data}
    logic [EW-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push, w_load, w_latch, w_empty, w_full;
    logic [EW-1:0]     w_head;

    // Frame configuration captured when a frame starts
    logic [DIV_W-1:0]  r_div;
    logic              r_cpol, r_cpha;

    // Timing and shift datapath
    logic [DIV_W-1:0]  r_cnt;
    logic [EGW-1:0]    r_edge;
    logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
    logic              r_mosi, r_sclk, r_dc, r_last, r_rx_valid;
    logic [NUM_CS-1:0] r_cs;

    logic              w_tick, w_final, w_edge_odd, w_xfer_tick;
    logic              w_sample, w_shift, w_cpha;
    logic [DATA_W-1:0] w_rx_nxt;

    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.i_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr];

    // One half-period has elapsed when the counter reaches div-1 (div already clamped to >=1)
    assign w_tick      = (r_cnt == r_div - DIV_W'(1));
    assign w_final     = (r_edge == EGW'(EDGES - 1));
    assign w_edge_odd  = ~r_edge[0];
    assign w_xfer_tick = (r_state == S_XFER) && w_tick;

    // Leading (odd) edges sample in CPHA=0 and drive in CPHA=1; the final edge never shifts
    assign w_cpha   = w_latch ? i_cpha : r_cpha;
    assign w_sample = w_xfer_tick && (r_cpha ? !w_edge_odd : w_edge_odd);
    assign w_shift  = w_xfer_tick && !w_final && (r_cpha ? w_edge_odd : !w_edge_odd);
    assign w_rx_nxt = w_sample ? ((r_rx << 1) | DATA_W'(miso)) : r_rx;

    assign bus.o_ready    = !w_full;
    assign bus.o_rx_data  = r_rx_data;
    assign bus.o_rx_valid = r_rx_valid;
    assign o_busy         = (r_state != S_IDLE) || !w_empty;
    assign mosi           = r_mosi;
    assign sclk           = r_sclk;
    assign dc             = r_dc;
    assign cs             = r_cs;

    // FIFO entry write; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.i_last, bus.i_dc, bus.i_data};
        end
    end

    // FIFO pointers and occupancy; a pop is any word load by the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM next state plus load/latch strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_SETUP;
                    w_load      = 1'b1;
                    w_latch     = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_tick) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_tick && w_final) w_state_nxt = S_NEXT;
            end
            S_NEXT, S_WAIT: begin
                if (r_last) begin
                    w_state_nxt = S_CS_HOLD;
                end else if (!w_empty) begin
                    w_state_nxt = S_XFER;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_CS_HOLD: begin
                if (w_tick) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Half-period counter restarts on every state change and at every half-period boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state || w_tick ||
                     r_state inside {S_IDLE, S_NEXT, S_WAIT}) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // SCLK edge counter within the current word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             r_edge <= '0;
        else if (w_load)      r_edge <= '0;
        else if (w_xfer_tick) r_edge <= r_edge + EGW'(1);
    end

    // Config latch, chip selects, shift registers and serial outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= DIV_W'(1);
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_dc       <= 1'b0;
            r_last     <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_cs       <= '1;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_latch) begin
                r_div  <= (i_div == '0) ? DIV_W'(1) : i_div;
                r_cpol <= i_cpol;
                r_cpha <= i_cpha;
                r_sclk <= i_cpol;
                // An out-of-range select matches no index, so every CS stays high
                for (int i = 0; i < NUM_CS; i++) begin
                    r_cs[i] <= (i_cs_sel != CS_W'(i));
                end
            end
            if (w_load) begin
                r_dc   <= w_head[DATA_W];
                r_last <= w_head[DATA_W+1];
                r_rx   <= '0;
                if (!w_cpha) begin
                    r_mosi <= w_head[DATA_W-1];
                    r_tx   <= w_head[DATA_W-1:0] << 1;
                end else begin
                    r_tx   <= w_head[DATA_W-1:0];
                end
            end else begin
                if (w_xfer_tick) r_sclk <= ~r_sclk;
                if (w_shift) begin
                    r_mosi <= r_tx[DATA_W-1];
                    r_tx   <= r_tx << 1;
                end
                r_rx <= w_rx_nxt;
                if (w_xfer_tick && w_final) begin
                    r_rx_data  <= w_rx_nxt;
                    r_rx_valid <= 1'b1;
                end
            end
            if (r_state == S_CS_HOLD && w_tick) r_cs <= '1;
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - self-checking bench for spi_master_param with an ideal SPI slave model
module tb_spi_master_param;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;
    localparam int NUM_CS = 2;
    localparam int FDEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_div = 8'd2;
    logic       i_cpol = 1'b0;
    logic       i_cpha = 1'b0;
    logic [0:0] i_cs_sel = 1'b0;
    logic       miso_r = 1'b0;
    logic       mosi, sclk, dc, o_busy;
    logic [1:0] cs;

    spi_master_param_if #(.DATA_W(DATA_W)) bus ();

    spi_master_param #(
        .DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_CS(NUM_CS), .FIFO_DEPTH(FDEPTH)
    ) dut (
        .clk(clk), .rst(rst), .i_div(i_div), .i_cpol(i_cpol), .i_cpha(i_cpha),
        .i_cs_sel(i_cs_sel), .bus(bus), .o_busy(o_busy), .miso(miso_r),
        .mosi(mosi), .sclk(sclk), .dc(dc), .cs(cs)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave model state: SPI mode of the current frame, observed words, returned words
    logic       m_cpol = 1'b0, m_cpha = 1'b0;
    logic [7:0] mon_mosi[$];
    logic       mon_dc[$];
    logic [7:0] slv_sent[$];
    logic [7:0] rx_got[$];
    logic [7:0] s_word = 8'h5A;
    logic [7:0] s_rx = 8'h00;
    logic       s_dc = 1'b0;
    int         s_nbits = 0;
    int         mon_frames = 0, cs_low_cyc = 0, dc_glitch = 0;
    logic [1:0] cs_low_bits = 2'b00;
    logic       p_sclk = 1'b0, p_csl = 1'b0;

    logic [7:0] f_data[8];
    logic       f_dc[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ideal slave: samples on rising edge when CPOL==CPHA else falling, drives on the other edge
    always @(posedge clk) begin
        logic csl;
        #1;
        csl = (cs != 2'b11);
        if (csl) begin
            cs_low_cyc++;
            cs_low_bits = cs_low_bits | ~cs;
        end
        if (csl && !p_csl) begin
            s_nbits = 0;
            if (!m_cpha) miso_r = s_word[7];
        end
        if (!csl && p_csl) begin
            mon_frames++;
            s_nbits = 0;
        end
        if (csl && p_csl && sclk != p_sclk) begin
            if (sclk == (m_cpol ~^ m_cpha)) begin
                s_rx = {s_rx[6:0], mosi};
                if (s_nbits == 0) s_dc = dc;
                else if (dc != s_dc) dc_glitch++;
                s_nbits++;
                if (s_nbits == 8) begin
                    mon_mosi.push_back(s_rx);
                    mon_dc.push_back(s_dc);
                    slv_sent.push_back(s_word);
                    s_word  = 8'($urandom);
                    s_nbits = 0;
                end
            end else begin
                miso_r = s_word[7 - s_nbits];
            end
        end
        p_sclk = sclk;
        p_csl  = csl;
    end

    // Collect every received-word strobe
    always @(posedge clk) begin
        #1;
        if (bus.o_rx_valid) rx_got.push_back(bus.o_rx_data);
    end

    task automatic clear_mon();
        mon_mosi.delete();
        mon_dc.delete();
        slv_sent.delete();
        rx_got.delete();
        mon_frames  = 0;
        cs_low_cyc  = 0;
        dc_glitch   = 0;
        cs_low_bits = 2'b00;
    endtask

    task automatic push_word(input logic [7:0] d, input logic c, input logic l);
        int t = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_dc    = c;
        bus.i_last  = l;
        while (!bus.o_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("push_timeout", 32'(t < 2000), 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic send_frame(input int nw);
        for (int i = 0; i < nw; i++) push_word(f_data[i], f_dc[i], (i == nw - 1));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (o_busy && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_timeout", 32'(t < 5000), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int nw, input logic [1:0] exp_cs);
        chk({tag, "_nwords"}, 32'(mon_mosi.size()), 32'(nw));
        chk({tag, "_nrx"}, 32'(rx_got.size()), 32'(nw));
        for (int i = 0; i < nw; i++) begin
            if (i < mon_mosi.size()) begin
                chk({tag, "_mosi"}, 32'(mon_mosi[i]), 32'(f_data[i]));
                chk({tag, "_dc"}, 32'(mon_dc[i]), 32'(f_dc[i]));
            end
            if (i < rx_got.size() && i < slv_sent.size())
                chk({tag, "_rx"}, 32'(rx_got[i]), 32'(slv_sent[i]));
        end
        chk({tag, "_frames"}, 32'(mon_frames), 32'd1);
        chk({tag, "_csbits"}, 32'(cs_low_bits), 32'(exp_cs));
        chk({tag, "_dcglitch"}, 32'(dc_glitch), 32'd0);
    endtask

    initial begin
        int nw;
        int dv;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_dc    = 1'b0;
        bus.i_last  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(cs), 32'h3);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_dc", 32'(dc), 32'h0);
        chk("rst_rxv", 32'(bus.o_rx_valid), 32'h0);
        chk("rst_rxd", 32'(bus.o_rx_data), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_ready", 32'(bus.o_ready), 32'h1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Mode 0, div 2, single word 0xA5
        m_cpol = 0; m_cpha = 0; i_cpol = 0; i_cpha = 0; i_div = 8'd2; i_cs_sel = 1'b0;
        f_data[0] = 8'hA5; f_dc[0] = 1'b0;
        clear_mon();
        send_frame(1);
        wait_idle();
        check_frame("m0", 1, 2'b01);
        chk("m0_cslow_min", 32'(cs_low_cyc >= 16*2 + 2*2), 32'd1);
        chk("m0_cslow_max", 32'(cs_low_cyc <= 16*2 + 2*2 + 2), 32'd1);
        chk("m0_idle_sclk", 32'(sclk), 32'h0);

        // Mode 3, div 1, 0x3C
        m_cpol = 1; m_cpha = 1; i_cpol = 1; i_cpha = 1; i_div = 8'd1;
        f_data[0] = 8'h3C; f_dc[0] = 1'b1;
        clear_mon();
        send_frame(1);
        wait_idle();
        check_frame("m3", 1, 2'b01);
        chk("m3_idle_sclk", 32'(sclk), 32'h1);

        // Stream of five words with back-pressure, dc rising at the second word
        m_cpol = 0; m_cpha = 0; i_cpol = 0; i_cpha = 0; i_div = 8'd2;
        f_data[0] = 8'h2A; f_dc[0] = 1'b0;
        f_data[1] = 8'h00; f_dc[1] = 1'b1;
        f_data[2] = 8'h00; f_dc[2] = 1'b1;
        f_data[3] = 8'h00; f_dc[3] = 1'b1;
        f_data[4] = 8'hEF; f_dc[4] = 1'b1;
        clear_mon();
        send_frame(5);
        chk("stream_full_ready", 32'(bus.o_ready), 32'h0);
        wait_idle();
        check_frame("stream", 5, 2'b01);
        chk("stream_nogap", 32'(cs_low_cyc <= 16*2*5 + 2*2 + 5 + 1), 32'd1);

        // Underrun: CS held low in WAIT with SCLK idle
        f_data[0] = 8'h11; f_dc[0] = 1'b0;
        f_data[1] = 8'h22; f_dc[1] = 1'b1;
        clear_mon();
        push_word(f_data[0], f_dc[0], 1'b0);
        repeat (50) @(posedge clk);
        #1;
        chk("wait_cs", 32'(cs), 32'h2);
        chk("wait_sclk", 32'(sclk), 32'h0);
        chk("wait_busy", 32'(o_busy), 32'h1);
        push_word(f_data[1], f_dc[1], 1'b1);
        wait_idle();
        check_frame("underrun", 2, 2'b01);

        // CS select 1; change of select mid-frame only affects the following frame
        m_cpol = 0; m_cpha = 1; i_cpol = 0; i_cpha = 1; i_div = 8'd1; i_cs_sel = 1'b1;
        f_data[0] = 8'h5C; f_dc[0] = 1'b0;
        f_data[1] = 8'hC5; f_dc[1] = 1'b1;
        clear_mon();
        send_frame(2);
        repeat (3) @(posedge clk);
        #1;
        i_cs_sel = 1'b0;
        wait_idle();
        check_frame("cs1", 2, 2'b10);
        f_data[0] = 8'h81; f_dc[0] = 1'b1;
        clear_mon();
        send_frame(1);
        wait_idle();
        check_frame("cs0", 1, 2'b01);

        // Reset in the middle of transferring 0xFF, with a second word still queued
        m_cpol = 0; m_cpha = 0; i_cpol = 0; i_cpha = 0; i_div = 8'd2;
        clear_mon();
        push_word(8'hFF, 1'b0, 1'b0);
        push_word(8'h77, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("mrst_cs", 32'(cs), 32'h3);
        chk("mrst_sclk", 32'(sclk), 32'h0);
        chk("mrst_mosi", 32'(mosi), 32'h0);
        chk("mrst_busy", 32'(o_busy), 32'h0);
        chk("mrst_ready", 32'(bus.o_ready), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mrst_norx", 32'(rx_got.size()), 32'd0);
        chk("mrst_nowords", 32'(mon_mosi.size()), 32'd0);
        f_data[0] = 8'h96; f_dc[0] = 1'b1;
        clear_mon();
        send_frame(1);
        wait_idle();
        check_frame("post_rst", 1, 2'b01);

        // Randomised frames: mode, divider (0 means 1), select, length and contents
        for (int f = 0; f < 8; f++) begin
            m_cpol   = 1'($urandom_range(0, 1));
            m_cpha   = 1'($urandom_range(0, 1));
            i_cpol   = m_cpol;
            i_cpha   = m_cpha;
            dv       = int'($urandom_range(0, 3));
            i_div    = 8'(dv);
            i_cs_sel = 1'($urandom_range(0, 1));
            nw       = int'($urandom_range(1, 7));
            for (int i = 0; i < nw; i++) begin
                f_data[i] = 8'($urandom);
                f_dc[i]   = 1'($urandom_range(0, 1));
            end
            clear_mon();
            send_frame(nw);
            wait_idle();
            check_frame("rnd", nw, (i_cs_sel == 1'b1) ? 2'b10 : 2'b01);
            chk("rnd_idle_sclk", 32'(sclk), 32'(m_cpol));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
